// File: rtl/bridge_uart_tx_arbiter.sv
// Shares one bridge UART transmitter between the master (command) and slave (response) framers, one whole frame per grant.
// Define BRIDGE_ARB_RESP_PRIO_EN so the slave port wins every tie; without it, ties are settled round-robin.
module bridge_uart_tx_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m_valid,
  input  logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_last,
  output logic                  m_ready,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic [1:0]            grant,
  output logic                  frame_done,
  output logic                  timeout_err
);
  localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, GRANT, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                state;
  logic                  rr_last;
  logic                  last_q;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_inc;
  logic                  handshake;
  logic                  pick_slave;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_last;

  assign m_ready   = (state == GRANT) && grant[0];
  assign s_ready   = (state == GRANT) && grant[1];
  assign handshake = (m_valid && m_ready) || (s_valid && s_ready);
  assign sel_data  = grant[1] ? s_data : m_data;
  assign sel_last  = grant[1] ? s_last : m_last;
  assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  // rr_last is 1 when the slave was served last, so on a tie the master goes next.
`ifdef BRIDGE_ARB_RESP_PRIO_EN
  assign pick_slave = s_valid;
`else
  assign pick_slave = s_valid && (!m_valid || !rr_last);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= 2'b00;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
      rr_last     <= 1'b1;
      last_q      <= 1'b0;
      cnt         <= '0;
    end else begin
      tx_start    <= 1'b0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (m_valid || s_valid) begin
            grant <= pick_slave ? 2'b10 : 2'b01;
            cnt   <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (handshake) begin
            tx_data  <= sel_data;
            last_q   <= sel_last;
            cnt      <= '0;
            tx_start <= 1'b1;
            state    <= LOAD;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              timeout_err <= 1'b1;
              rr_last     <= grant[1];
              grant       <= 2'b00;
              state       <= IDLE;
            end
          end
        end
        LOAD: state <= WAIT_BUSY;
        WAIT_BUSY: begin
          if (tx_busy) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (last_q) begin
              frame_done <= 1'b1;
              rr_last    <= grant[1];
              grant      <= 2'b00;
              state      <= IDLE;
            end else begin
              state <= GRANT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bridge_uart_tx_arbiter.sv
// Directed bench for bridge_uart_tx_arbiter, using a UART model that raises busy one cycle after start and holds it for 20 cycles.
`timescale 1ns/1ps
module tb_bridge_uart_tx_arbiter;
  localparam int DW = 8;
  localparam int TO = 50;

  logic          clk = 1'b0;
  logic          rst;
  logic          m_valid, m_last, m_ready;
  logic [DW-1:0] m_data;
  logic          s_valid, s_last, s_ready;
  logic [DW-1:0] s_data;
  logic [DW-1:0] tx_data;
  logic          tx_start, tx_busy;
  logic [1:0]    grant;
  logic          frame_done, timeout_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int fd_cnt, to_cnt;
  bit lock_viol;
  logic [8:0]    m_q[$];
  logic [8:0]    s_q[$];
  logic [DW-1:0] tx_log[$];
  logic [1:0]    gr_log[$];

  bridge_uart_tx_arbiter #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .grant(grant), .frame_done(frame_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // The UART byte in flight is never cancelled by the arbiter's reset.
  always @(posedge clk) begin
    if (tx_start) busy_cnt <= 20;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt > 0);

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic driveSources();
    m_valid = (m_q.size() > 0);
    {m_last, m_data} = (m_q.size() > 0) ? m_q[0] : 9'h000;
    s_valid = (s_q.size() > 0);
    {s_last, s_data} = (s_q.size() > 0) ? s_q[0] : 9'h000;
  endtask

  // Advance one clock, retire accepted bytes and log what the DUT did in the new cycle.
  task automatic applyStimulus();
    logic hm, hs;
    hm = m_valid && m_ready;
    hs = s_valid && s_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (hm && m_q.size() > 0) m_q.delete(0);
    if (hs && s_q.size() > 0) s_q.delete(0);
    driveSources();
    if (tx_start) begin
      tx_log.push_back(tx_data);
      gr_log.push_back(grant);
    end
    if (frame_done) fd_cnt++;
    if (timeout_err) to_cnt++;
    if ((grant == 2'b01 && s_ready) || (grant == 2'b10 && m_ready)) lock_viol = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] logAt(input int i);
    return (i < tx_log.size()) ? 32'(tx_log[i]) : 32'hDEAD;
  endfunction

  function automatic logic [31:0] grAt(input int i);
    return (i < gr_log.size()) ? 32'(gr_log[i]) : 32'hDEAD;
  endfunction

  task automatic resetDut();
    rst = 1'b1;
    m_q.delete();
    s_q.delete();
    driveSources();
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    tx_log.delete();
    gr_log.delete();
    fd_cnt = 0;
    to_cnt = 0;
    lock_viol = 1'b0;
  endtask

  task automatic runUntilDone(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      applyStimulus();
      n++;
    end while (!frame_done && n < budget);
    checkOutput({tag, "_frame_done"}, 32'(frame_done), 1);
    checkOutput({tag, "_grant_idle"}, 32'(grant), 0);
  endtask

  initial begin
    int c0, reentry, t_rel;
    bit seen_low;
    logic [1:0] exp_gr;
    rst = 1'b1;
    m_q.delete();
    s_q.delete();
    driveSources();
    resetDut();

    checkOutput("rst_grant", 32'(grant), 0);
    checkOutput("rst_m_ready", 32'(m_ready), 0);
    checkOutput("rst_s_ready", 32'(s_ready), 0);
    checkOutput("rst_tx_start", 32'(tx_start), 0);
    checkOutput("rst_tx_data", 32'(tx_data), 0);
    checkOutput("rst_frame_done", 32'(frame_done), 0);
    checkOutput("rst_timeout_err", 32'(timeout_err), 0);

    // Master-only three-byte frame
    m_q = '{9'h0A1, 9'h0B2, 9'h1C3};
    driveSources();
    applyStimulus();
    checkOutput("s1_grant_c1", 32'(grant), 32'b01);
    checkOutput("s1_m_ready_c1", 32'(m_ready), 1);
    applyStimulus();
    checkOutput("s1_tx_start_c2", 32'(tx_start), 1);
    checkOutput("s1_tx_data_c2", 32'(tx_data), 32'hA1);
    runUntilDone("s1", 200);
    checkOutput("s1_count", 32'(tx_log.size()), 3);
    checkOutput("s1_byte0", logAt(0), 32'hA1);
    checkOutput("s1_byte1", logAt(1), 32'hB2);
    checkOutput("s1_byte2", logAt(2), 32'hC3);
    checkOutput("s1_grant_b1", grAt(1), 32'b01);
    checkOutput("s1_grant_b2", grAt(2), 32'b01);
    checkOutput("s1_fd_count", 32'(fd_cnt), 1);

    // Both sources valid out of reset
    resetDut();
    m_q = '{9'h011, 9'h122};
    s_q = '{9'h133};
    driveSources();
    runUntilDone("s2a", 200);
    checkOutput("s2_count_a", 32'(tx_log.size()), 2);
    checkOutput("s2_byte0", logAt(0), 32'h11);
    checkOutput("s2_byte1", logAt(1), 32'h22);
    checkOutput("s2_grant0", grAt(0), 32'b01);
    checkOutput("s2_lock", 32'(lock_viol), 0);
    checkOutput("s2_slave_pending", 32'(s_q.size()), 1);
    runUntilDone("s2b", 200);
    checkOutput("s2_count_b", 32'(tx_log.size()), 3);
    checkOutput("s2_byte2", logAt(2), 32'h33);
    checkOutput("s2_grant2", grAt(2), 32'b10);

    // Master stalls after a non-last byte
    resetDut();
    m_q = '{9'h055};
    driveSources();
    c0 = cyc;
    reentry = -1;
    t_rel = -1;
    seen_low = 1'b0;
    for (int i = 0; i < 200 && t_rel < 0; i++) begin
      applyStimulus();
      if (!m_ready && i > 0) seen_low = 1'b1;
      if (m_ready && seen_low && reentry < 0) reentry = cyc - c0;
      if (timeout_err) t_rel = cyc - c0;
    end
    checkOutput("s3_reentry_cycle", 32'(reentry), 24);
    checkOutput("s3_timeout_cycle", 32'(t_rel), 74);
    checkOutput("s3_grant_after_abort", 32'(grant), 0);
    for (int i = 0; i < 30; i++) applyStimulus();
    checkOutput("s3_no_more_start", 32'(tx_log.size()), 1);
    checkOutput("s3_byte0", logAt(0), 32'h55);
    s_q = '{9'h166};
    driveSources();
    runUntilDone("s3", 200);
    checkOutput("s3_slave_grant", grAt(1), 32'b10);
    checkOutput("s3_slave_byte", logAt(1), 32'h66);
    checkOutput("s3_to_count", 32'(to_cnt), 1);

    // One-byte frames with both sources continuously valid
    resetDut();
    for (int i = 0; i < 4; i++) begin
      m_q.push_back(9'h1A0 + 9'(i));
      s_q.push_back(9'h1B0 + 9'(i));
    end
    driveSources();
    for (int i = 0; i < 4; i++) runUntilDone("s4", 200);
    for (int i = 0; i < 4; i++) begin
`ifdef BRIDGE_ARB_RESP_PRIO_EN
      exp_gr = 2'b10;
`else
      exp_gr = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
      checkOutput($sformatf("s4_grant%0d", i), grAt(i), 32'(exp_gr));
    end
`ifdef BRIDGE_ARB_RESP_PRIO_EN
    checkOutput("s4_byte0", logAt(0), 32'hB0);
`else
    checkOutput("s4_byte0", logAt(0), 32'hA0);
    checkOutput("s4_byte1", logAt(1), 32'hB0);
`endif

    // Reset lands while the second byte waits for busy
    resetDut();
    m_q = '{9'h001, 9'h002, 9'h103};
    driveSources();
    for (int i = 0; i < 26; i++) applyStimulus();
    checkOutput("s5_second_byte", logAt(1), 32'h02);
    rst = 1'b1;
    applyStimulus();
    checkOutput("s5_rst_grant", 32'(grant), 0);
    checkOutput("s5_rst_tx_start", 32'(tx_start), 0);
    checkOutput("s5_rst_m_ready", 32'(m_ready), 0);
    checkOutput("s5_rst_s_ready", 32'(s_ready), 0);
    rst = 1'b0;
    m_q.delete();
    m_q.push_back(9'h17E);
    driveSources();
    fd_cnt = 0;
    applyStimulus();
    checkOutput("s5_grant_c1", 32'(grant), 32'b01);
    checkOutput("s5_m_ready_c1", 32'(m_ready), 1);
    applyStimulus();
    checkOutput("s5_tx_start_c2", 32'(tx_start), 1);
    checkOutput("s5_tx_data_c2", 32'(tx_data), 32'h7E);
    runUntilDone("s5", 200);
    checkOutput("s5_fd_count", 32'(fd_cnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bridge_uart_tx_arbiter.md
# bridge_uart_tx_arbiter

Shares one bridge UART transmitter between two frame sources: the bridge master, which sends outbound command frames, and the bridge slave, which sends outbound response frames. The block grants the link to one source for a whole frame and paces bytes into the UART TX using its start/busy handshake. It aborts a stalled frame after a timeout. It sits between the bridge master/slave framers and the UART TX inside the bus bridge.

## Interface
- `DATA_WIDTH`, 8: byte width of the stream and UART data.
- `TIMEOUT_CYCLES`, 100000: clocks a granted source may stall mid-frame before abort. Must exceed one UART byte time (~52080 clocks at 5208 clocks/bit).
- `clk`  in  1  system clock (50 MHz).
- `rst`  in  1  synchronous reset, active-high.
- `m_valid`  in  1  bridge-master byte valid.
- `m_data`  in  DATA_WIDTH  bridge-master byte.
- `m_last`  in  1  marks the final byte of the master frame.
- `m_ready`  out  1  master byte accepted when `m_valid && m_ready`.
- `s_valid`, `s_data`, `s_last`, `s_ready`: same as the `m_` signals, for the bridge-slave response stream.
- `tx_data`  out  DATA_WIDTH  byte to the UART TX (registered).
- `tx_start`  out  1  one-cycle UART start pulse.
- `tx_busy`  in  1  UART TX is shifting.
- `grant`  out  2  one-hot owner: [0] master, [1] slave. 00 when idle.
- `frame_done`  out  1  one-cycle pulse after the last byte of a frame finishes.
- `timeout_err`  out  1  one-cycle pulse when a frame is aborted.

## Operation
- FSM states: IDLE, GRANT, LOAD, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Arbitrates on `m_valid` / `s_valid`.
  - The winner is registered into `grant`; go to GRANT.
  - If neither source is valid, stay in IDLE.
- Arbitration (default): round-robin. If both sources are valid, the port not served last wins. `rr_last` resets to slave, so master wins the first tie.
- GRANT:
  - `x_ready` = 1 for the granted port only; it is combinational from state and grant.
  - On a handshake: capture data into `tx_data` and `last` into `last_q`; clear the timeout counter; go to LOAD.
  - Otherwise the timeout counter increments. When it reaches `TIMEOUT_CYCLES`: pulse `timeout_err`, clear `grant`, set `rr_last` to the aborted port, go to IDLE.
- LOAD: `tx_start` = 1 for exactly one cycle; go to WAIT_BUSY.
- WAIT_BUSY: wait for `tx_busy` = 1, then go to WAIT_DONE.
- WAIT_DONE: wait for `tx_busy` = 0.
  - If `last_q`: pulse `frame_done`, set `rr_last` to the owner, clear `grant`, go to IDLE.
  - Otherwise go to GRANT; the timeout counter is already cleared.
- Grant lock: the non-owner's ready stays 0 for the whole frame, regardless of its valid.
- Timeout counter width is `$clog2(TIMEOUT_CYCLES+1)` and it saturates; it never wraps.
- A 1-byte frame (valid with `last` on the first byte) is legal.

## Timing
- Reset values:
  - state = IDLE
  - `grant` = 00
  - `m_ready` = `s_ready` = 0
  - `tx_start` = 0
  - `tx_data` = 0
  - `frame_done` = `timeout_err` = 0
  - `rr_last` = slave
  - counter = 0
- Request to `tx_start` latency:
  - cycle 0: IDLE samples valid.
  - cycle 1: GRANT, byte handshake.
  - cycle 2: `tx_start` high, with `tx_data` stable from this cycle until the next capture.
- Next byte: the earliest handshake is 2 cycles after `tx_busy` falls (WAIT_DONE → GRANT → handshake in GRANT).
- `frame_done` is asserted in the cycle after `tx_busy` is sampled low in WAIT_DONE. `grant` is 00 in that same cycle.
- Simultaneous `frame_done` and a new request: the new request is arbitrated on the following IDLE cycle using the updated `rr_last`.
- Reset mid-frame (any state): everything returns to reset values on the next edge. An in-flight UART byte is not cancelled, and the frame is not resumed.
- `tx_busy` asserted while in IDLE or GRANT is ignored.

## Configuration
- `BRIDGE_ARB_RESP_PRIO_EN`
  - Defined: fixed priority, and the slave (response) port always wins a tie. This prevents remote-master deadlock. `rr_last` is still maintained but unused for the decision.
  - Undefined: round-robin as described above.
- The grant lock and timeout behave identically in both builds.

## Test plan
- Bench setup: `TIMEOUT_CYCLES`=50. The UART model raises `tx_busy` 1 cycle after `tx_start` and holds it for 20 cycles.
- Master-only 3-byte frame A1,B2,C3 (last on C3):
  - 3 `tx_start` pulses with `tx_data` = A1, B2, C3 in order.
  - `grant` = 01 throughout.
  - one `frame_done`, then `grant` = 00.
- Both valid from reset, master frame 11,22 and slave frame 33:
  - master is granted first, and `s_ready` stays 0 until `frame_done`.
  - then slave is granted and 33 is sent.
  - total 3 `tx_start` pulses.
- Stall: master sends byte 55 (not last), then drops `m_valid`:
  - `timeout_err` pulses 50 GRANT cycles after the re-entry to GRANT.
  - `grant` = 00 and no further `tx_start`.
  - a following slave request is granted.
- 1-byte frames alternating with both sources always valid:
  - grants alternate 01, 10, 01, 10 in round-robin.
  - with `BRIDGE_ARB_RESP_PRIO_EN` defined, every grant is 10 while `s_valid` stays high.
- Assert `rst` in WAIT_BUSY of the second byte:
  - next cycle: `grant` = 00, `tx_start` = 0, ready outputs 0.
  - a subsequent master frame 7E is sent with the normal 2-cycle latency.
